// File: rtl/div_seq_ctrl.sv
// Multi-cycle restoring divider for the EX stage: one quotient bit per cycle,
// stalls the pipeline while busy and returns {remainder, quotient} for HI/LO.
module div_seq_ctrl #(
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            signed_div,
  input  logic [DW-1:0]   opdata1,
  input  logic [DW-1:0]   opdata2,
  input  logic            annul,
  output logic [2*DW-1:0] result,
  output logic            ready,
  output logic            stallreq_for_div
);

  localparam int unsigned CW = $clog2(DW);

  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] dvd, dvs, rem, quo;
  logic [CW-1:0] cnt;
  logic          sgn_a, sgn_b, sgn_mode;

  logic [DW:0]   trial;
  logic [DW-1:0] rem_nx, quo_nx, rem_fix, quo_fix;
  logic          last, abort;

  always_comb begin
    trial   = {rem, dvd[DW-1]} - {1'b0, dvs};
    rem_nx  = trial[DW] ? {rem[DW-2:0], dvd[DW-1]} : trial[DW-1:0];
    quo_nx  = {quo[DW-2:0], ~trial[DW]};
    // Magnitudes were divided; restore signs (quotient by sign xor, remainder follows dividend)
    quo_fix = (sgn_mode && (sgn_a ^ sgn_b)) ? -quo_nx : quo_nx;
    rem_fix = (sgn_mode && sgn_a) ? -rem_nx : rem_nx;
    last    = (cnt == CW'(DW - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FREE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx         = state;
    stallreq_for_div = 1'b0;
    abort            = annul || !start;
    case (state)
      FREE: begin
        if (start && !annul) begin
          stallreq_for_div = 1'b1;
          state_nx         = (opdata2 == '0) ? BY_ZERO : ON;
        end
      end
      BY_ZERO: begin
        stallreq_for_div = 1'b1;
        state_nx         = abort ? FREE : END;
      end
      ON: begin
        stallreq_for_div = 1'b1;
        if (abort)     state_nx = FREE;
        else if (last) state_nx = END;
      end
      END: begin
        if (abort) state_nx = FREE;
      end
      default: state_nx = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      ready    <= 1'b0;
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      quo      <= '0;
      sgn_a    <= 1'b0;
      sgn_b    <= 1'b0;
      sgn_mode <= 1'b0;
    end else begin
      ready <= (state_nx == END);
      if (state == FREE && state_nx == ON) begin
        dvd      <= (signed_div && opdata1[DW-1]) ? -opdata1 : opdata1;
        dvs      <= (signed_div && opdata2[DW-1]) ? -opdata2 : opdata2;
        sgn_a    <= opdata1[DW-1];
        sgn_b    <= opdata2[DW-1];
        sgn_mode <= signed_div;
        rem      <= '0;
        quo      <= '0;
        cnt      <= '0;
      end
      if (state == ON && state_nx != FREE) begin
        dvd <= dvd << 1;
        rem <= rem_nx;
        quo <= quo_nx;
        cnt <= cnt + 1'b1;
        if (state_nx == END) result <= {rem_fix, quo_fix};
      end
      if (state == BY_ZERO && state_nx == END) result <= '0;
    end
  end

endmodule
